// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE -> ACCESS -> DONE handshake between CPU and a 32-bit data memory.
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        dm_cs,
    output logic        dm_w,
    output logic        dm_r,
    output logic [2:0]  dm_select,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_go_access;
    logic [2:0]  w_select_in;
    logic [31:0] w_load_ext;

    logic        r_busy, r_done, r_addr_err;
    logic        r_dm_cs, r_dm_w, r_dm_r;
    logic        r_we, r_sign_ext;
    logic [2:0]  r_dm_select;
    logic [31:0] r_rdata, r_dm_addr, r_dm_wdata;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misaligned = ((size == 2'b01) && addr[0]) ||
                          (size[1] && (addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Size 11 is folded into word so the memory never sees an undefined select.
    always_comb begin
        case (size)
            2'b00:   w_select_in = 3'b001;
            2'b01:   w_select_in = 3'b010;
            default: w_select_in = 3'b100;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misaligned ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_go_access = w_accept && !w_misaligned;

    // Big-endian memory: the addressed byte/half sits in the top of the read word.
    always_comb begin
        case (r_dm_select)
            3'b001:  w_load_ext = {{24{r_sign_ext & dm_rdata[31]}}, dm_rdata[31:24]};
            3'b010:  w_load_ext = {{16{r_sign_ext & dm_rdata[31]}}, dm_rdata[31:16]};
            default: w_load_ext = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_dm_cs     <= 1'b0;
            r_dm_w      <= 1'b0;
            r_dm_r      <= 1'b0;
            r_we        <= 1'b0;
            r_sign_ext  <= 1'b0;
            r_dm_select <= 3'b000;
            r_rdata     <= 32'h0;
            r_dm_addr   <= 32'h0;
            r_dm_wdata  <= 32'h0;
        end else begin
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_addr_err <= w_accept && w_misaligned;
            r_dm_cs    <= w_go_access;
            r_dm_w     <= w_go_access && we;
            r_dm_r     <= w_go_access && !we;
            if (w_accept) begin
                r_we       <= we;
                r_sign_ext <= sign_ext;
            end
            // Memory-side address/data only move when a strobe will follow.
            if (w_go_access) begin
                r_dm_addr   <= addr;
                r_dm_select <= w_select_in;
                r_dm_wdata  <= wdata;
            end
            if ((r_state == S_ACCESS) && !r_we) r_rdata <= w_load_ext;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign addr_err  = r_addr_err;
    assign rdata     = r_rdata;
    assign dm_cs     = r_dm_cs;
    assign dm_w      = r_dm_w;
    assign dm_r      = r_dm_r;
    assign dm_select = r_dm_select;
    assign dm_addr   = r_dm_addr;
    assign dm_wdata  = r_dm_wdata;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: none; all widths fixed at 32-bit data and address.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  1  CPU access request, sampled only in IDLE.
REQ-005 we  in  1  1=store, 0=load.
REQ-006 size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
REQ-007 sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 busy  out  1  high in every non-IDLE state.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result; holds until the next load completes.
REQ-013 addr_err  out  1  misaligned-access flag, valid while done=1.
REQ-014 dm_cs, dm_w, dm_r  out  1 each  data-memory chip select, write strobe and read strobe.
REQ-015 dm_select  out  3  100=word, 010=half, 001=byte.
REQ-016 dm_addr  out  32  memory address.
REQ-017 dm_wdata  out  32  memory write data.
REQ-018 dm_rdata  in  32  combinational big-endian read word {M[a],M[a+1],M[a+2],M[a+3]}.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and DONE. All outputs are registered.
REQ-020 IDLE with req=1 SHALL latch we, size, sign_ext, addr and wdata.
- Aligned request: next state ACCESS.
- Misaligned request: next state DONE with addr_err=1, and no memory strobe is issued.
REQ-021 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 In ACCESS the block SHALL hold dm_cs=1, dm_w=we, dm_r=~we, and keep dm_addr, dm_select and dm_wdata stable for the whole cycle, so the memory's negedge write sees settled inputs.
REQ-023 In ACCESS the block SHALL capture dm_rdata at the closing posedge, then go to DONE.
REQ-024 dm_wdata SHALL equal the latched wdata unmodified; the memory takes bits [7:0] for byte and [15:0] for half.
REQ-025 Load extraction SHALL be:
- byte: dm_rdata[31:24], extended to 32 bits.
- half: dm_rdata[31:16], extended to 32 bits.
- word: dm_rdata as is.
REQ-026 In DONE the block SHALL assert done=1 for exactly one cycle, then return to IDLE.
- rdata updates only for successful loads.
REQ-027 Latency, with req sampled at edge N:
- Aligned access: done at cycle N+2.
- Misaligned access: done at cycle N+1.
REQ-028 req asserted while busy=1 SHALL be ignored and not queued; a new request is accepted in the cycle after done.
REQ-029 Outside ACCESS, dm_cs, dm_w and dm_r SHALL be 0, and dm_addr, dm_select and dm_wdata SHALL hold their last values.

Reset
REQ-030 While rst=1 at a posedge the block SHALL enter IDLE and clear:
- busy, done and addr_err to 0;
- dm_cs, dm_w and dm_r to 0;
- rdata, dm_addr and dm_wdata to 32'h0;
- dm_select to 3'b000.
REQ-031 Reset during ACCESS SHALL abort the operation with no done pulse. A store whose ACCESS cycle began before the reset edge may already have committed at that cycle's negedge, and this is permitted.
REQ-032 rst SHALL take priority over req in the same cycle.

Configuration
REQ-033 Macro LSU_ALIGN_CHECK_EN defined: alignment checking SHALL follow REQ-020 and REQ-021.
REQ-034 Macro LSU_ALIGN_CHECK_EN undefined: every request SHALL go to ACCESS at the given address, and addr_err SHALL be tied to 0.

Verification
REQ-035 Word store then load:
- Stimulus: store addr=0x10, wdata=0xDEADBEEF, size=10; then load addr=0x10, size=10.
- Response: rdata=0xDEADBEEF; each done arrives 2 cycles after req.
REQ-036 Byte extension:
- Stimulus: memory byte 0x20=0x80; lb with sign_ext=1, then with sign_ext=0.
- Response: rdata=0xFFFFFF80, then rdata=0x00000080.
REQ-037 Half store:
- Stimulus: sh addr=0x22, wdata=0x1234ABCD; then lw addr=0x20.
- Response: bytes 0x22=0xAB and 0x23=0xCD; bytes 0x20-0x21 unchanged.
REQ-038 Misaligned access, macro defined:
- Stimulus: lw addr=0x31.
- Response: done and addr_err=1 one cycle after req; dm_cs never asserts; rdata unchanged.
REQ-039 Reset mid-load:
- Stimulus: rst=1 during ACCESS.
- Response: next cycle all outputs at reset values; no done pulse; a fresh req is accepted afterwards.
REQ-040 Back-to-back request:
- Stimulus: req held high continuously.
- Response: one access per 3 cycles; no request accepted while busy=1.
